ttt_board_ctrl: RTL and testbench
=================================

Name: ttt_board_ctrl

Overview:
- Game-sequencing controller for the single-player tic-tac-toe display.
- Owns the 3x3 board occupancy vector and the one-hot cursor that drive the VGA graphics block's cell-mark and cursor-highlight inputs.
- Consumes pre-debounced, single-cycle button pulses. Moves the cursor, places marks, and detects three-in-a-row.
- Sits between the button conditioning logic and the graphics renderer.

Parameters:
- CURSOR_INIT, 4, cell index (0-8, row-major, cell = row*3 + col) loaded into the cursor on reset and on new game.
- WRAP, 1, 1 = cursor wraps at grid edges; 0 = cursor saturates at grid edges.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  one-cycle pulse: move cursor up one row.
- btn_down  input  1  one-cycle pulse: move cursor down one row.
- btn_left  input  1  one-cycle pulse: move cursor left one column.
- btn_right  input  1  one-cycle pulse: move cursor right one column.
- btn_center  input  1  one-cycle pulse: place a mark at the cursor.
- btn_new  input  1  one-cycle pulse: clear the board and start a new game.
- occupied  output  9  registered board; bit i = cell i marked. Feeds the graphics sw input.
- cursor_onehot  output  9  registered one-hot cursor. Feeds the graphics cell_select_flag input.
- place_pulse  output  1  one-cycle strobe when a mark is accepted.
- move_count  output  4  number of marks placed, 0-9.
- win  output  1  high while the game is won; held until new game or reset.
- win_line  output  8  one-hot index of the first completed line (rows 0-2, cols 3-5, diag 6, anti-diag 7); 0 when no win.

Behaviour:
- Reset (synchronous, active-high, takes effect from any state in one edge):
  - state=PLAY, occupied=0, cursor=CURSOR_INIT (cursor_onehot=1<<CURSOR_INIT)
  - place_pulse=0, move_count=0, win=0, win_line=0
- All outputs are registered. There is no combinational path from any input to any output.
- Per-cycle input priority: reset > btn_new > btn_center > movement. Exactly one action is taken per cycle.
- Movement priority when several direction pulses coincide: up > down > left > right. Only the highest-priority direction is applied.
- btn_center and a direction pulse in the same cycle: the mark is placed at the current cursor and the move is discarded.
- Cursor movement:
  - Internal 4-bit index, row = idx/3, col = idx%3.
  - Cursor movement is accepted in PLAY only.
  - New cursor_onehot is visible the cycle after the pulse.
  - WRAP=1: right at col 2 goes to col 0 of the same row; left at col 0 goes to col 2; down at row 2 goes to row 0; up at row 0 goes to row 2.
  - WRAP=0: a move at an edge leaves the cursor unchanged.
- States:
  - PLAY: btn_center on an empty cell sets occupied[idx], increments move_count, pulses place_pulse next cycle, and goes to CHECK. btn_center on an occupied cell does nothing (no pulse, no state change).
  - CHECK (exactly 1 cycle): evaluate the registered occupied vector against the 8 line masks. Any match sets win=1, win_line = lowest-indexed matching line, and goes to DONE. Otherwise return to PLAY. Cursor and center inputs are ignored in CHECK.
  - DONE: all movement and center pulses are ignored; win and win_line are held.
- Timing: btn_center sampled at edge N gives occupied, move_count and place_pulse visible after N+1. A winning placement gives win visible after N+2.
- btn_new in any state (PLAY, CHECK, DONE) gives the reset values above after the next edge; a pending CHECK is abandoned and win stays 0.
- move_count saturates at 9. A full board always contains a line, so DONE is reached before move_count can exceed 9.

Decomposition:
- Package ttt_pkg:
  - state enum {PLAY, CHECK, DONE}
  - constants NUM_CELLS=9, GRID=3
  - LINE_MASK[0:7] 9-bit win masks (rows 0x007, 0x038, 0x1C0; cols 0x049, 0x092, 0x124; diagonals 0x111, 0x054)
- Sub-module ttt_win_detect: combinational; occupied[8:0] -> any_win, line_onehot[7:0] with lowest-index priority. It is instantiated once, in the CHECK path.

Test Plan:
1. Assert reset 2 cycles -> cursor_onehot=9'h010, occupied=0, move_count=0, win=0, win_line=0.
2. Two btn_right pulses from cell 4 -> cursor 5, then 3 (wrap). Two btn_down pulses -> 6, then 0. With WRAP=0, btn_right at cell 5 -> stays 5.
3. btn_center at cell 4 -> occupied=9'h010, place_pulse high exactly 1 cycle, move_count=1. A second btn_center at cell 4 -> no change, no pulse.
4. Place cells 0, 1, 2 -> win=1 and win_line=8'h01 two cycles after the third center pulse. Further btn_center/btn_right pulses -> occupied and cursor unchanged.
5. btn_center and btn_up in the same cycle at cell 4 -> cell 4 marked, cursor stays 4. btn_up and btn_left together at cell 4 -> cursor 1.
6. btn_new coincident with btn_center during CHECK -> next cycle occupied=0, cursor=9'h010, state PLAY, win=0. Mid-game reset gives the same result.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types, grid constants and line masks for the tic-tac-toe board controller.
// Also holds the cursor-step helper so movement rules live in one place.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam int NUM_CELLS = 9;
  localparam int GRID      = 3;
  localparam int NUM_LINES = 8;

  // Rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
  localparam logic [NUM_CELLS-1:0] LINE_MASK [0:NUM_LINES-1] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  // Apply one direction to a row-major cell index; edges wrap or saturate.
  function automatic logic [3:0] cursor_step(input logic [3:0] idx,
                                             input dir_e       dir,
                                             input logic       wrap);
    logic [3:0] row;
    logic [3:0] col;
    row = idx / 4'(GRID);
    col = idx % 4'(GRID);
    case (dir)
      DIR_UP: begin
        if (row != 4'd0)    row = row - 4'd1;
        else if (wrap)      row = 4'(GRID - 1);
      end
      DIR_DOWN: begin
        if (row != 4'(GRID - 1)) row = row + 4'd1;
        else if (wrap)           row = 4'd0;
      end
      DIR_LEFT: begin
        if (col != 4'd0)    col = col - 4'd1;
        else if (wrap)      col = 4'(GRID - 1);
      end
      DIR_RIGHT: begin
        if (col != 4'(GRID - 1)) col = col + 4'd1;
        else if (wrap)           col = 4'd0;
      end
      default: ;
    endcase
    return row * 4'(GRID) + col;
  endfunction

  function automatic logic [NUM_CELLS-1:0] idx_to_onehot(input logic [3:0] idx);
    return 9'b1 << idx;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector over the board occupancy vector.
// Reports whether any line is complete and the lowest-indexed complete line, one-hot.
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] occupied,
  output logic                 any_win,
  output logic [NUM_LINES-1:0] line_onehot
);

  logic [NUM_LINES-1:0] hits;

  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      hits[i] = ((occupied & LINE_MASK[i]) == LINE_MASK[i]);
    end
  end

  // Scan downwards so the lowest matching line is the one left standing.
  always_comb begin
    line_onehot = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (hits[i]) line_onehot = 8'b1 << i;
    end
  end

  assign any_win = |hits;

endmodule

// File: rtl/ttt_board_ctrl.sv
// Game sequencer: owns board occupancy and cursor, takes single-cycle button pulses,
// places marks and latches the first completed line. All outputs come from flops.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter int CURSOR_INIT = 4,
  parameter bit WRAP        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_center,
  input  logic                 btn_new,
  output logic [NUM_CELLS-1:0] occupied,
  output logic [NUM_CELLS-1:0] cursor_onehot,
  output logic                 place_pulse,
  output logic [3:0]           move_count,
  output logic                 win,
  output logic [NUM_LINES-1:0] win_line
);

  localparam logic [3:0] CUR_IDX_INIT = 4'(CURSOR_INIT);

  state_e                 state_q, state_d;
  logic [NUM_CELLS-1:0]   occ_q, occ_d;
  logic [3:0]             cur_idx_q, cur_idx_d;
  logic [NUM_CELLS-1:0]   cur_oh_q, cur_oh_d;
  logic                   pulse_q, pulse_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   win_q, win_d;
  logic [NUM_LINES-1:0]   line_q, line_d;

  logic                   det_any;
  logic [NUM_LINES-1:0]   det_line;
  dir_e                   dir_sel;
  logic                   place_ok;

  ttt_win_detect u_win_detect (
    .occupied    (occ_q),
    .any_win     (det_any),
    .line_onehot (det_line)
  );

  // Only the highest-priority direction survives: up > down > left > right.
  always_comb begin
    dir_sel = DIR_NONE;
    if (btn_up)         dir_sel = DIR_UP;
    else if (btn_down)  dir_sel = DIR_DOWN;
    else if (btn_left)  dir_sel = DIR_LEFT;
    else if (btn_right) dir_sel = DIR_RIGHT;
  end

  assign place_ok = btn_center && !occ_q[cur_idx_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY;
      occ_q     <= '0;
      cur_idx_q <= CUR_IDX_INIT;
      cur_oh_q  <= idx_to_onehot(CUR_IDX_INIT);
      pulse_q   <= 1'b0;
      cnt_q     <= 4'd0;
      win_q     <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      cur_idx_q <= cur_idx_d;
      cur_oh_q  <= cur_oh_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      line_q    <= line_d;
    end
  end

  // Next-state: btn_new beats everything; CHECK always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    if (btn_new) begin
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY:    if (place_ok) state_d = CHECK;
        CHECK:   state_d = det_any ? DONE : PLAY;
        DONE:    state_d = DONE;
        default: state_d = PLAY;
      endcase
    end
  end

  // Board, cursor and result updates; a center press always swallows any move.
  always_comb begin
    occ_d     = occ_q;
    cur_idx_d = cur_idx_q;
    cur_oh_d  = cur_oh_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    win_d     = win_q;
    line_d    = line_q;
    if (btn_new) begin
      occ_d     = '0;
      cur_idx_d = CUR_IDX_INIT;
      cur_oh_d  = idx_to_onehot(CUR_IDX_INIT);
      cnt_d     = 4'd0;
      win_d     = 1'b0;
      line_d    = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (btn_center) begin
            if (place_ok) begin
              occ_d   = occ_q | idx_to_onehot(cur_idx_q);
              pulse_d = 1'b1;
              cnt_d   = (cnt_q == 4'(NUM_CELLS)) ? cnt_q : cnt_q + 4'd1;
            end
          end else if (dir_sel != DIR_NONE) begin
            cur_idx_d = cursor_step(cur_idx_q, dir_sel, WRAP);
            cur_oh_d  = idx_to_onehot(cur_idx_d);
          end
        end
        CHECK: begin
          if (det_any) begin
            win_d  = 1'b1;
            line_d = det_line;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    occupied      = occ_q;
    cursor_onehot = cur_oh_q;
    place_pulse   = pulse_q;
    move_count    = cnt_q;
    win           = win_q;
    win_line      = line_q;
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed bench for ttt_board_ctrl: cursor moves (wrap and saturate), placement,
// row-0 win, button priorities, and btn_new / reset from mid-game and CHECK.
module tb_ttt_board_ctrl;
  import ttt_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center, btn_new;
  logic [8:0] occupied, cursor_onehot, nw_occupied, nw_cursor_onehot;
  logic       place_pulse, win, nw_place_pulse, nw_win;
  logic [3:0] move_count, nw_move_count;
  logic [7:0] win_line, nw_win_line;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [5:0] B_NEW = 6'b100000;
  localparam logic [5:0] B_CEN = 6'b010000;
  localparam logic [5:0] B_UP  = 6'b001000;
  localparam logic [5:0] B_DN  = 6'b000100;
  localparam logic [5:0] B_LF  = 6'b000010;
  localparam logic [5:0] B_RT  = 6'b000001;

  always #5 clk = ~clk;

  ttt_board_ctrl #(.CURSOR_INIT(4), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center), .btn_new(btn_new),
    .occupied(occupied), .cursor_onehot(cursor_onehot), .place_pulse(place_pulse),
    .move_count(move_count), .win(win), .win_line(win_line)
  );

  // Saturating instance shares the buttons; only its cursor is checked.
  ttt_board_ctrl #(.CURSOR_INIT(4), .WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center), .btn_new(btn_new),
    .occupied(nw_occupied), .cursor_onehot(nw_cursor_onehot), .place_pulse(nw_place_pulse),
    .move_count(nw_move_count), .win(nw_win), .win_line(nw_win_line)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive buttons for one edge; on return, that edge's results are visible.
  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {btn_new, btn_center, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    #1;
    {btn_new, btn_center, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {btn_new, btn_center, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    idle(2);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_cursor", 32'(cursor_onehot), 32'h010);
    chk("rst_occ",    32'(occupied),      32'h000);
    chk("rst_count",  32'(move_count),    32'd0);
    chk("rst_win",    32'(win),           32'd0);
    chk("rst_line",   32'(win_line),      32'h00);
    chk("rst_pulse",  32'(place_pulse),   32'd0);
    chk("rst_state",  32'(dut.state_q),   32'(PLAY));

    // Movement with wrap, and saturation on the WRAP=0 copy
    press(B_RT); chk("right_4to5",      32'(cursor_onehot),    32'h020);
                 chk("nw_right_4to5",   32'(nw_cursor_onehot), 32'h020);
    press(B_RT); chk("right_wrap_5to3", 32'(cursor_onehot),    32'h008);
                 chk("nw_right_sat5",   32'(nw_cursor_onehot), 32'h020);
    press(B_DN); chk("down_3to6",       32'(cursor_onehot),    32'h040);
                 chk("nw_down_5to8",    32'(nw_cursor_onehot), 32'h100);
    press(B_DN); chk("down_wrap_6to0",  32'(cursor_onehot),    32'h001);
                 chk("nw_down_sat8",    32'(nw_cursor_onehot), 32'h100);
    press(B_DN); press(B_RT);
    chk("back_to_4", 32'(cursor_onehot), 32'h010);

    // Placement at cell 4, then a repeat press on the same cell
    press(B_CEN);
    chk("place_occ",   32'(occupied),    32'h010);
    chk("place_pulse", 32'(place_pulse), 32'd1);
    chk("place_count", 32'(move_count),  32'd1);
    chk("place_check", 32'(dut.state_q), 32'(CHECK));
    idle(1);
    chk("pulse_drop",  32'(place_pulse), 32'd0);
    chk("back_play",   32'(dut.state_q), 32'(PLAY));
    press(B_CEN);
    chk("dup_occ",   32'(occupied),    32'h010);
    chk("dup_pulse", 32'(place_pulse), 32'd0);
    chk("dup_count", 32'(move_count),  32'd1);

    // Complete row 0: cells 0, 1, 2
    press(B_UP); press(B_LF);
    chk("cursor_at0", 32'(cursor_onehot), 32'h001);
    press(B_CEN); idle(1);
    press(B_RT); press(B_CEN); idle(1);
    press(B_RT); press(B_CEN);
    chk("win_occ",      32'(occupied),   32'h017);
    chk("win_count",    32'(move_count), 32'd4);
    chk("win_not_yet",  32'(win),        32'd0);
    idle(1);
    chk("win_set",      32'(win),        32'd1);
    chk("win_line_row", 32'(win_line),   32'h01);
    chk("win_done",     32'(dut.state_q), 32'(DONE));
    press(B_LF); press(B_CEN); press(B_RT);
    chk("done_cursor", 32'(cursor_onehot), 32'h004);
    chk("done_occ",    32'(occupied),      32'h017);
    chk("done_win",    32'(win),           32'd1);
    chk("done_line",   32'(win_line),      32'h01);

    // New game, then center beats up, and up beats left
    press(B_NEW);
    chk("new_occ",    32'(occupied),      32'h000);
    chk("new_cursor", 32'(cursor_onehot), 32'h010);
    chk("new_win",    32'(win),           32'd0);
    chk("new_count",  32'(move_count),    32'd0);
    press(B_CEN | B_UP);
    chk("cen_up_occ",    32'(occupied),      32'h010);
    chk("cen_up_cursor", 32'(cursor_onehot), 32'h010);
    idle(1);
    press(B_UP | B_LF);
    chk("up_left_cursor", 32'(cursor_onehot), 32'h002);
    press(B_DN | B_RT);
    chk("down_right_cursor", 32'(cursor_onehot), 32'h010);

    // btn_new during a winning CHECK abandons the win
    press(B_UP); press(B_LF);
    press(B_CEN); idle(1);
    press(B_RT); press(B_CEN); idle(1);
    press(B_RT); press(B_CEN);
    chk("pend_check", 32'(dut.state_q), 32'(CHECK));
    press(B_NEW | B_CEN);
    chk("abandon_occ",    32'(occupied),      32'h000);
    chk("abandon_cursor", 32'(cursor_onehot), 32'h010);
    chk("abandon_state",  32'(dut.state_q),   32'(PLAY));
    chk("abandon_win",    32'(win),           32'd0);
    idle(1);
    chk("abandon_win_hold", 32'(win),      32'd0);
    chk("abandon_line",     32'(win_line), 32'h00);

    // Mid-game synchronous reset
    press(B_CEN); idle(1); press(B_RT);
    chk("mid_occ_pre", 32'(occupied), 32'h010);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_occ",    32'(occupied),      32'h000);
    chk("mrst_cursor", 32'(cursor_onehot), 32'h010);
    chk("mrst_count",  32'(move_count),    32'd0);
    chk("mrst_state",  32'(dut.state_q),   32'(PLAY));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
